// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: funct3 branch encodings,
// 2-bit saturating counter type and its reset value, and helper functions.
package bru_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef logic [1:0] ctr_t;

  // Weakly not-taken.
  localparam ctr_t CTR_RST = 2'b01;
  localparam ctr_t CTR_MAX = 2'b11;
  localparam ctr_t CTR_MIN = 2'b00;

  function automatic logic br_legal(input logic [2:0] t);
    return (t[2:1] != 2'b01);
  endfunction

  // Resolve the branch from precomputed compare flags so the function stays width-agnostic.
  function automatic logic br_taken(input logic [2:0] t, input logic eq,
                                    input logic lt_s, input logic lt_u);
    logic tk;
    tk = 1'b0;
    case (br_type_e'(t))
      BR_BEQ:  tk = eq;
      BR_BNE:  tk = !eq;
      BR_BLT:  tk = lt_s;
      BR_BGE:  tk = !lt_s;
      BR_BLTU: tk = lt_u;
      BR_BGEU: tk = !lt_u;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != CTR_MAX) n = c + 2'd1;
    end else begin
      if (c != CTR_MIN) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: ENTRIES 2-bit saturating counters with one
// combinational read port and one synchronous update port (read-before-write).
module bru_bht
  import bru_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [ENTRIES-1:0][1:0] ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RST;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

  // Read sees the registered value, so a same-cycle lookup returns the pre-update count.
  assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, registers the result behind a
// valid/ready handshake and trains a 2-bit BHT. Optional BRU_STATS_EN adds counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      in_type,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } rsp_t;

  rsp_t       rsp_q, rsp_d;
  logic       vld_q;
  logic       accept;
  logic       legal;
  logic       eq, lt_s, lt_u;
  logic [1:0] rd_ctr;
  logic       upd_en;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign eq    = (in_a == in_b);
  assign lt_s  = ($signed(in_a) < $signed(in_b));
  assign lt_u  = (in_a < in_b);
  assign legal = br_legal(in_type);

  always_comb begin
    rsp_d            = '0;
    rsp_d.illegal    = !legal;
    rsp_d.taken      = legal && br_taken(in_type, eq, lt_s, lt_u);
    rsp_d.mispredict = rsp_d.taken ^ in_pred_taken;
    rsp_d.pc         = in_pc;
  end

  // Payload only reloads on accept, so it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      if (accept) begin
        vld_q <= 1'b1;
        rsp_q <= rsp_d;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_q;
  assign out_taken      = rsp_q.taken;
  assign out_mispredict = rsp_q.mispredict;
  assign out_illegal    = rsp_q.illegal;
  assign out_pc         = rsp_q.pc;

  assign upd_en = accept && legal;

  bru_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pred_pc[IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (in_pc[IDX_W+1:2]),
    .upd_taken (rsp_d.taken)
  );

  assign pred_taken = rd_ctr[1];

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (rsp_d.mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  // PC bits outside the BHT index do not feed the predictor.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            in_pc[XLEN-1:IDX_W+2], in_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results queued on accept,
// popped when the DUT hands a result over. Define BRU_STATS_EN to check stats.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int ENT  = 16;
  localparam int IW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] pred_pc = '0;
  logic            pred_taken;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_a = '0, in_b = '0, in_pc = '0;
  logic [2:0]      in_type = '0;
  logic            in_pred_taken = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0] out_pc;
`ifdef BRU_STATS_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_type        (in_type),
    .in_pc          (in_pc),
    .in_pred_taken  (in_pred_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_pc         (out_pc)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic        taken;
    logic        misp;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [1:0]  mdl[ENT];
  logic [31:0] m_br, m_mp;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ref_ctr(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) mdl[i] = 2'b01;
    m_br = '0;
    m_mp = '0;
    sbq.delete();
  endtask

  // Drive one request and hold it until accepted; queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t,
                      input logic [31:0] pc, input logic pt);
    int   n;
    int   ix;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_type = t; in_pc = pc;
    in_pred_taken = pt; pred_pc = pc;
    @(negedge clk);
    if (out_ready) chk("in_rdy_flow", in_ready, 1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    ix = pc[IW+1:2];
    chk("pred_rbw", pred_taken, mdl[ix][1]);
    e.taken = ref_taken(t, a, b);
    e.misp  = e.taken ^ pt;
    e.ill   = (t == 3'b010) || (t == 3'b011);
    e.pc    = pc;
    sbq.push_back(e);
    if (!e.ill) begin
      mdl[ix] = ref_ctr(mdl[ix], e.taken);
      m_br = m_br + 32'd1;
      if (e.misp) m_mp = m_mp + 32'd1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    @(posedge clk); #1;
    pred_pc = pc;
    #1;
    chk(tag, pred_taken, exp);
    chk({tag, "_mdl"}, pred_taken, mdl[pc[IW+1:2]][1]);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_taken", out_taken, e.taken);
        chk("out_misp",  out_mispredict, e.misp);
        chk("out_ill",   out_illegal, e.ill);
        chk("out_pc",    out_pc, e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hp;
    logic        ht;
    int          n;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_taken",  out_taken, 0);
    chk("rst_misp",   out_mispredict, 0);
    chk("rst_ill",    out_illegal, 0);
    chk("rst_pc",     out_pc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_irdy", in_ready, 1);
    check_pred("pred_init", 32'h100, 1'b0);

    // BEQ taken against a not-taken prediction trains idx 0 to 2.
    send(32'd5, 32'd5, 3'b000, 32'h100, 1'b0);
    idle();
    check_pred("pred_after_beq", 32'h100, 1'b1);

    // Illegal encodings leave the counter alone.
    send(32'd1, 32'd2, 3'b010, 32'h100, 1'b1);
    send(32'd3, 32'd3, 3'b011, 32'h100, 1'b0);
    idle();
    check_pred("pred_after_ill", 32'h100, 1'b1);

    // Signed vs unsigned on the same operands.
    send(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h200, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h200, 1'b1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'h200, 1'b1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h200, 1'b0);
    send(32'd7, 32'd9, 3'b001, 32'h200, 1'b1);
    idle();

    // Saturation at idx 1: 2,3,3 then 2,1.
    send(32'd0, 32'd0, 3'b000, 32'h304, 1'b0);
    idle(); check_pred("sat_c2", 32'h304, 1'b1);
    send(32'd0, 32'd0, 3'b000, 32'h304, 1'b1);
    idle(); check_pred("sat_c3", 32'h304, 1'b1);
    send(32'd0, 32'd0, 3'b000, 32'h304, 1'b1);
    idle(); check_pred("sat_c3b", 32'h304, 1'b1);
    send(32'd0, 32'd1, 3'b000, 32'h304, 1'b1);
    idle(); check_pred("sat_c2b", 32'h304, 1'b1);
    send(32'd0, 32'd1, 3'b000, 32'h304, 1'b1);
    idle(); check_pred("sat_c1", 32'h304, 1'b0);

    // Random back-to-back traffic over indices 4..15.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(a, b, 3'($urandom_range(0, 7)),
           32'h1000 + (32'($urandom_range(4, 15)) << 2), 1'($urandom_range(0, 1)));
    end
    idle();

    // Backpressure: consumer stalls 3 cycles, then drains one per cycle.
    out_ready = 1'b0;
    fork
      begin
        send(32'd4, 32'd4, 3'b000, 32'h100, 1'b1);
        send(32'd1, 32'd2, 3'b110, 32'h100, 1'b1);
        send(32'd2, 32'd1, 3'b111, 32'h100, 1'b0);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_ovalid", out_valid, 1);
        hp = out_pc;
        ht = out_taken;
        repeat (3) begin
          @(negedge clk);
          chk("bp_irdy",  in_ready, 0);
          chk("bp_ovld",  out_valid, 1);
          chk("bp_pc",    out_pc, hp);
          chk("bp_taken", out_taken, ht);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle();
    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    check_pred("pred_pre_rst", 32'h100, 1'b1);
`ifdef BRU_STATS_EN
    chk("stat_br", stat_branches, m_br);
    chk("stat_mp", stat_mispredicts, m_mp);
`endif

    // Reset while a result is pending: it is dropped and the BHT reinitialises.
    out_ready = 1'b0;
    send(32'd1, 32'd1, 3'b000, 32'h100, 1'b0);
    idle();
    @(negedge clk);
    chk("rst_mid_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", out_valid, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_mid_irdy", in_ready, 1);
    chk("rst_mid_pc", out_pc, 0);
    check_pred("rst_mid_pred", 32'h100, 1'b0);
`ifdef BRU_STATS_EN
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mp", stat_mispredicts, 0);
`endif
    send(32'd3, 32'd2, 3'b101, 32'h108, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    chk("sb_final", sbq.size(), 0);
`ifdef BRU_STATS_EN
    chk("stat_br_end", stat_branches, m_br);
    chk("stat_mp_end", stat_mispredicts, m_mp);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
